// File: rtl/uart_tx_module_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and the parity helper.
// The receive side imports the same package.
package uart_tx_module_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Even parity is the XOR of the byte; odd parity inverts it.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_module_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last cycle of each bit.
// restart realigns the count so the first bit starts on the acceptance edge.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_module.sv
// UART transmitter: accepts {address, data} via valid/ack and sends
// start, 8 data bits LSB first, optional parity, stop on Tx.
module uart_tx_module
  import uart_tx_module_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [3:0] address,
  input  logic [3:0] data,
  output logic       ack,
  output logic       busy,
  output logic       Tx,
  output logic       tx_done
);

  uart_state_e          state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 restart;
  logic                 bit_end;

  assign restart = (state_q == IDLE) && valid;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d = {address, data};
          par_d   = parity_bit({address, data}, PARITY_ODD);
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          tx_d    = START_LEVEL;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = STOP_LEVEL;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = STOP_LEVEL;
        end
      end
      STOP: begin
        // Returning to IDLE here leaves one idle cycle before the next acceptance.
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = STOP_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= STOP_LEVEL;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= '0;
      bit_q   <= 3'd0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign Tx      = tx_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: three configurations (even, odd, no parity) driven with the
// same stimulus and checked every cycle against a frame-level model, plus literal expectations.
module tb_uart_tx_module;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       ack_w[3];
  logic       busy_w[3];
  logic       tx_w[3];
  logic       done_w[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_module #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .data(data),
    .ack(ack_w[0]), .busy(busy_w[0]), .Tx(tx_w[0]), .tx_done(done_w[0]));

  uart_tx_module #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .data(data),
    .ack(ack_w[1]), .busy(busy_w[1]), .Tx(tx_w[1]), .tx_done(done_w[1]));

  uart_tx_module #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .data(data),
    .ack(ack_w[2]), .busy(busy_w[2]), .Tx(tx_w[2]), .tx_done(done_w[2]));

  function automatic bit cfg_pen(input int i);
    return (i != 2);
  endfunction

  function automatic bit cfg_odd(input int i);
    return (i == 1);
  endfunction

  // Frame bit k: 0 = start, 1..8 = data LSB first, 9 = parity (if enabled), last = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k, input bit pen, input bit odd);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && pen) return (^b) ^ odd;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, dut, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycles since acceptance and derives the line from the frame position.
  bit         m_live[3];
  bit         m_busy[3];
  int         m_cyc[3];
  logic [7:0] m_byte[3];
  logic       e_ack[3], e_busy[3], e_tx[3], e_done[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      e_ack[i]  = 1'b0;
      e_done[i] = 1'b0;
      if (rst) begin
        m_live[i] = 1'b1;
        m_busy[i] = 1'b0;
        e_busy[i] = 1'b0;
        e_tx[i]   = 1'b1;
      end else if (!m_busy[i]) begin
        if (valid) begin
          m_busy[i] = 1'b1;
          m_cyc[i]  = 0;
          m_byte[i] = {address, data};
          e_ack[i]  = 1'b1;
          e_busy[i] = 1'b1;
          e_tx[i]   = 1'b0;
        end else begin
          e_busy[i] = 1'b0;
          e_tx[i]   = 1'b1;
        end
      end else begin
        m_cyc[i]++;
        if (m_cyc[i] == (10 + int'(cfg_pen(i))) * CPB) begin
          m_busy[i] = 1'b0;
          e_busy[i] = 1'b0;
          e_done[i] = 1'b1;
          e_tx[i]   = 1'b1;
        end else begin
          e_busy[i] = 1'b1;
          e_tx[i]   = frame_bit(m_byte[i], m_cyc[i] / CPB, cfg_pen(i), cfg_odd(i));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_live[i]) begin
        check("model_ack", i, 32'(ack_w[i]), 32'(e_ack[i]));
        check("model_busy", i, 32'(busy_w[i]), 32'(e_busy[i]));
        check("model_tx", i, 32'(tx_w[i]), 32'(e_tx[i]));
        check("model_done", i, 32'(done_w[i]), 32'(e_done[i]));
      end
    end
  end

  logic [10:0] cap_bits[3];
  int          cap_busy[3];
  int          cap_done[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (ack_w[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_ack_timeout"}, 0, 32'd0, 32'd1);
  endtask

  task automatic send_pulse(input logic [3:0] a, input logic [3:0] d, input string name);
    address = a;
    data    = d;
    valid   = 1'b1;
    wait_ack(name);
    valid   = 1'b0;
  endtask

  // Called right after the ack edge; c counts cycles since acceptance.
  task automatic capture();
    for (int i = 0; i < 3; i++) begin
      cap_bits[i] = '0;
      cap_busy[i] = 0;
      cap_done[i] = -1;
    end
    for (int c = 0; c < 56; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ((c % CPB) == CPB / 2 && (c / CPB) < 11) cap_bits[i][c / CPB] = tx_w[i];
        if (busy_w[i]) cap_busy[i]++;
        if (done_w[i] && cap_done[i] < 0) cap_done[i] = c;
      end
      tick();
    end
  endtask

  initial begin
    int gap;
    int hi;
    int ack_at;
    int dn;
    int len;
    logic [10:0] exp_bits;

    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    int hi;
    int ack_at;
    int dn;
    int len;
    logic [10:0] exp_bits;

    rst = 1'b1; valid = 1'b0; address = 4'h0; data = 4'h0;
    repeat (3) tick();
    check("reset_tx", 0, 32'(tx_w[0]), 32'd1);
    check("reset_busy", 0, 32'(busy_w[0]), 32'd0);
    check("reset_ack", 0, 32'(ack_w[0]), 32'd0);
    check("reset_done", 0, 32'(done_w[0]), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 0xA5 even parity: start, A5 LSB first, parity 0, stop.
    send_pulse(4'hA, 4'h5, "A");
    capture();
    exp_bits = 11'b1_0_10100101_0;
    check("A_bits", 0, 32'(cap_bits[0]), 32'(exp_bits));
    check("A_busy_cycles", 0, 32'(cap_busy[0]), 32'd44);
    check("A_done_at", 0, 32'(cap_done[0]), 32'd44);

    // 0x01: parity polarity and parity-less framing.
    send_pulse(4'h0, 4'h1, "B");
    capture();
    check("B_par_even", 0, 32'(cap_bits[0][9]), 32'd1);
    check("B_par_odd", 1, 32'(cap_bits[1][9]), 32'd0);
    check("B_nopar_stop_after_d7", 2, 32'(cap_bits[2][9]), 32'd1);
    check("B_nopar_busy", 2, 32'(cap_busy[2]), 32'd40);
    check("B_nopar_done_at", 2, 32'(cap_done[2]), 32'd40);

    // Back-to-back with valid held: 0x3C then 0xC3.
    address = 4'h3; data = 4'hC; valid = 1'b1;
    wait_ack("C1");
    address = 4'hC; data = 4'h3;
    gap = 0; hi = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c >= 40 && tx_w[0]) hi++;
      if (ack_w[0]) begin
        gap = c;
        break;
      end
    end
    valid = 1'b0;
    check("C_ack_spacing", 0, 32'(gap), 32'd45);
    check("C_idle_high", 0, 32'(hi), 32'd5);
    repeat (60) tick();

    // Requests while busy; inputs changed mid-frame.
    send_pulse(4'h1, 4'h2, "D");
    ack_at = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin valid = 1'b1; address = 4'hF; data = 4'hE; end
      if (c == 20) begin address = 4'h6; data = 4'h9; end
      tick();
      if (ack_w[0]) begin
        ack_at = c;
        break;
      end
    end
    valid = 1'b0;
    check("D_ack_first_idle", 0, 32'(ack_at), 32'd45);
    repeat (60) tick();

    // Reset during data bit 3 (cycles 16..19 after acceptance).
    send_pulse(4'h5, 4'hA, "E");
    repeat (16) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("E_rst_tx", 0, 32'(tx_w[0]), 32'd1);
    check("E_rst_busy", 0, 32'(busy_w[0]), 32'd0);
    dn = 0;
    for (int c = 0; c < 50; c++) begin
      if (done_w[0]) dn++;
      tick();
    end
    check("E_no_done", 0, 32'(dn), 32'd0);
    send_pulse(4'h9, 4'h6, "E2");
    capture();
    exp_bits = 11'b1_0_10010110_0;
    check("E2_bits", 0, 32'(cap_bits[0]), 32'(exp_bits));
    check("E2_done_at", 0, 32'(cap_done[0]), 32'd44);

    // rst and valid together: reset wins.
    rst = 1'b1; valid = 1'b1; address = 4'h7; data = 4'h7;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("F_ack", i, 32'(ack_w[i]), 32'd0);
      check("F_tx", i, 32'(tx_w[i]), 32'd1);
      check("F_busy", i, 32'(busy_w[i]), 32'd0);
    end
    rst = 1'b0; valid = 1'b0;
    tick();
    send_pulse(4'h7, 4'h7, "F2");
    capture();
    check("F2_done_at", 0, 32'(cap_done[0]), 32'd44);

    // Random traffic: pulses that may drop early, occasional resets, random gaps.
    for (int r = 0; r < 30; r++) begin
      address = 4'($urandom_range(0, 15));
      data    = 4'($urandom_range(0, 15));
      valid   = 1'b1;
      len     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 200;
      for (int k = 0; k < len; k++) begin
        tick();
        if (ack_w[0]) break;
        if (k == 2) begin
          address = 4'($urandom_range(0, 15));
          data    = 4'($urandom_range(0, 15));
        end
      end
      valid = 1'b0;
      repeat ($urandom_range(0, 60)) tick();
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
